siso_seq_ctrl: RTL and testbench

- Controller that sequences a serial-in/serial-out shift-register chain of DEPTH stages as a loopback channel.
- Accepts a parallel word through a valid/ready handshake and clears the chain.
- Drives the word out serially on the chain's d input, then re-assembles the bits returning on the chain's q output.
- Reports completion and a match flag; used for self-test and serial transport over the team's SISO register.

---
 rtl/siso_pkg.sv | 29 ++
 rtl/siso_bit_ctr.sv | 53 +++++
 rtl/siso_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_siso_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | siso_pkg : shared state type and index helpers for siso_seq_ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package siso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W     = $clog2(WIDTH_DEF + DEPTH_DEF + 1);

  function automatic int cnt_width(input int width, input int depth);
    return $clog2(width + depth + 1);
  endfunction

  // Word bit carried by serial slot 'slot' of the send/receive order.
  function automatic int bit_idx(input int slot, input int width, input bit msb_first);
    return msb_first ? (width - 1 - slot) : slot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/siso_bit_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | siso_bit_ctr : saturating slot counter with drive/sample windows   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module siso_bit_ctr
  import siso_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int CNT_BITS = CNT_W
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                sclr_i,
  input  logic                en_i,
  output logic [CNT_BITS-1:0] cnt_o,
  output logic                tc_o,
  output logic                drive_en_o,
  output logic                sample_en_o
);

  localparam logic [CNT_BITS-1:0] LAST    = CNT_BITS'(WIDTH + DEPTH - 1);
  localparam logic [CNT_BITS-1:0] DRV_END = CNT_BITS'(WIDTH);
  localparam logic [CNT_BITS-1:0] SMP_LO  = CNT_BITS'(DEPTH);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // Holds at the terminal count instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (sclr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign tc_o        = (cnt_q == LAST);
  assign drive_en_o  = (cnt_q < DRV_END);
  assign sample_en_o = (cnt_q >= SMP_LO) && (cnt_q <= LAST);

endmodule
`default_nettype wire

// File: rtl/siso_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | siso_seq_ctrl : sends a word through a SISO chain and re-assembles |
// |                 it from the chain output. Rev 1.0                  |
// +--------------------------------------------------------------------+
module siso_seq_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             abort,
  output logic             sr_d,
  output logic             sr_clr,
  input  logic             sr_q,
  output logic [WIDTH-1:0] rx_data,
  output logic             done,
  output logic             match,
  output logic             aborted,
  output logic             busy
);

  localparam int                  CNT_BITS = cnt_width(WIDTH, DEPTH);
  localparam logic [CNT_BITS-1:0] LAST_DRV = CNT_BITS'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic                sr_d_q, sr_d_d, done_q, done_d;
  logic                match_q, match_d, aborted_q, aborted_d;
  logic [CNT_BITS-1:0] cnt;
  logic                tc, drive_en, sample_en, in_shift, tx_bit;
  logic [WIDTH-1:0]    rx_mask, rx_bit;
  int                  nxt_idx, rx_idx;

  assign in_shift = (state_q == SHIFT);

  siso_bit_ctr #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .CNT_BITS (CNT_BITS)
  ) u_ctr (
    .clk         (clk),
    .clr         (clr),
    .sclr_i      (!in_shift),
    .en_i        (in_shift),
    .cnt_o       (cnt),
    .tc_o        (tc),
    .drive_en_o  (drive_en),
    .sample_en_o (sample_en)
  );

  // sr_d is registered, so it is loaded with the bit of the slot about to start.
  assign nxt_idx = bit_idx(in_shift ? int'(cnt) + 1 : 0, WIDTH, MSB_FIRST);
  assign tx_bit  = |(tx_q & (WIDTH'(1) << nxt_idx));
  assign rx_idx  = bit_idx(int'(cnt) - DEPTH, WIDTH, MSB_FIRST);
  assign rx_mask = WIDTH'(1) << rx_idx;
  assign rx_bit  = WIDTH'(sr_q) << rx_idx;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    match_d   = match_q;
    sr_d_d    = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          tx_d    = tx_data;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          sr_d_d  = tx_bit;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          if (sample_en) begin
            rx_sh_d = (rx_sh_q & ~rx_mask) | rx_bit;
          end
          if (tc) begin
            state_d = DONE;
          end else if (drive_en && (cnt != LAST_DRV)) begin
            sr_d_d = tx_bit;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        rx_d    = rx_sh_q;
        match_d = (rx_sh_q == tx_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      sr_d_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      sr_d_q    <= sr_d_d;
      done_q    <= done_d;
      match_q   <= match_d;
      aborted_q <= aborted_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign sr_clr      = (state_q == CLEAR) | ~clr;
  assign sr_d        = sr_d_q;
  assign rx_data     = rx_q;
  assign done        = done_q;
  assign match       = match_q;
  assign aborted     = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_siso_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_siso_seq_ctrl : two controllers (MSB/LSB first) on 4-stage SISO  |
// |                    chains, checked against a transaction model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_siso_seq_ctrl;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int LAT = W + D + 2;

  logic         clk = 1'b0;
  logic         clr, start_valid, abort, tie0, sel;
  logic [W-1:0] tx_data;

  logic         sv_a, rdy_a, srd_a, srclr_a, srq_a, done_a, match_a, abt_a, busy_a;
  logic         sv_b, rdy_b, srd_b, srclr_b, srq_b, done_b, match_b, abt_b, busy_b;
  logic [W-1:0] rx_a, rx_b;
  logic [D-1:0] ch_a, ch_b;

  logic         rdy_m, srd_m, srclr_m, done_m, match_m, abt_m, busy_m;
  logic [W-1:0] rx_m;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_rx [2];
  bit           model_m  [2];

  always #5 clk = ~clk;

  siso_seq_ctrl #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .clr(clr), .start_valid(sv_a), .start_ready(rdy_a), .tx_data(tx_data),
    .abort(abort), .sr_d(srd_a), .sr_clr(srclr_a), .sr_q(srq_a), .rx_data(rx_a),
    .done(done_a), .match(match_a), .aborted(abt_a), .busy(busy_a)
  );

  siso_seq_ctrl #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .clr(clr), .start_valid(sv_b), .start_ready(rdy_b), .tx_data(tx_data),
    .abort(abort), .sr_d(srd_b), .sr_clr(srclr_b), .sr_q(srq_b), .rx_data(rx_b),
    .done(done_b), .match(match_b), .aborted(abt_b), .busy(busy_b)
  );

  // Attached SISO chains (synchronous active-high clear)
  always_ff @(posedge clk) begin
    ch_a <= srclr_a ? '0 : {ch_a[D-2:0], srd_a};
    ch_b <= srclr_b ? '0 : {ch_b[D-2:0], srd_b};
  end

  assign srq_a   = tie0 ? 1'b0 : ch_a[D-1];
  assign srq_b   = tie0 ? 1'b0 : ch_b[D-1];
  assign sv_a    = start_valid & ~sel;
  assign sv_b    = start_valid & sel;
  assign rdy_m   = sel ? rdy_b   : rdy_a;
  assign srd_m   = sel ? srd_b   : srd_a;
  assign srclr_m = sel ? srclr_b : srclr_a;
  assign done_m  = sel ? done_b  : done_a;
  assign match_m = sel ? match_b : match_a;
  assign abt_m   = sel ? abt_b   : abt_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign rx_m    = sel ? rx_b    : rx_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request on DUT s (0: MSB first, 1: LSB first). abort_k / rst_k give the
  // cycle after acceptance (0 = CLEAR cycle) in which abort / clr=0 is applied; -1 = none.
  task automatic xfer(input bit s, input logic [W-1:0] tx, input bit t0,
                      input int abort_k, input int rst_k);
    logic [W-1:0] exp_rx;
    bit           cut, eb;
    int           slot;
    sel  = s;
    tie0 = t0;
    check_eq("idle_rdy", rdy_m, 1);
    start_valid = 1'b1;
    tx_data     = tx;
    abort       = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    tx_data     = W'($urandom);
    check_eq("acc_rdy", rdy_m, 0);
    check_eq("acc_busy", busy_m, 1);
    check_eq("clear_sr_clr", srclr_m, 1);
    abort  = (abort_k == 0);
    exp_rx = t0 ? '0 : tx;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      cut  = (abort_k >= 0 && k > abort_k) || (rst_k >= 0 && k > rst_k);
      slot = k - 1;
      eb   = 1'b0;
      if (!cut && k <= W + D && slot < W) eb = s ? tx[slot] : tx[W-1-slot];
      check_eq($sformatf("sr_d k%0d tx%0h", k, tx), srd_m, eb);
      check_eq($sformatf("done k%0d", k), done_m, !cut && k == LAT);
      check_eq($sformatf("aborted k%0d", k), abt_m, abort_k >= 0 && k == abort_k + 1);
      if (!cut && k == LAT) begin
        model_rx[s] = exp_rx;
        model_m[s]  = (exp_rx == tx);
      end
      if ((!cut && k == LAT) || k == abort_k + 1 || k == rst_k + 1) begin
        check_eq($sformatf("rx k%0d", k), rx_m, model_rx[s]);
        check_eq($sformatf("match k%0d", k), match_m, model_m[s]);
      end
      if (k == abort_k + 1 || k == rst_k + 1 || k == LAT + 1) begin
        check_eq($sformatf("end_busy k%0d", k), busy_m, 0);
        check_eq($sformatf("end_rdy k%0d", k), rdy_m, 1);
      end
      abort = (k == abort_k);
      if (k == rst_k) begin
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
          model_rx[i] = '0;
          model_m[i]  = 1'b0;
        end
        #1 check_eq("rst_sr_clr", srclr_m, 1);
      end else begin
        clr = 1'b1;
      end
    end
    abort = 1'b0;
  endtask

  initial begin
    int           nd;
    int           d_k [2];
    logic [W-1:0] d_rx [2];
    bit           d_m [2];
    int           ak;
    clr = 1'b0; start_valid = 1'b0; abort = 1'b0; tie0 = 1'b0; sel = 1'b0; tx_data = '0;
    for (int i = 0; i < 2; i++) begin
      model_rx[i] = '0;
      model_m[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_m, 0);
    check_eq("rst_rdy", rdy_m, 1);
    check_eq("rst_done", done_m, 0);
    check_eq("rst_rx", rx_m, 0);
    check_eq("rst_match", match_m, 0);
    check_eq("rst_aborted", abt_m, 0);
    check_eq("rst_sr_d", srd_m, 0);
    check_eq("rst_sr_clr_held", srclr_m, 1);
    clr = 1'b1;
    @(negedge clk);
    check_eq("run_sr_clr", srclr_m, 0);

    xfer(0, 8'hA5, 0, -1, -1);
    xfer(0, 8'hFF, 1, -1, -1);

    // Back-to-back: start_valid held high across the first completion.
    sel = 1'b0; tie0 = 1'b0; nd = 0;
    start_valid = 1'b1; tx_data = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'hC3;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (done_m) begin
        if (nd < 2) begin
          d_k[nd] = k; d_rx[nd] = rx_m; d_m[nd] = match_m;
        end
        nd++;
      end
      if (k == LAT)     check_eq("b2b_gap_busy", busy_m, 0);
      if (k == LAT + 1) begin
        check_eq("b2b_second_busy", busy_m, 1);
        start_valid = 1'b0;
      end
    end
    check_eq("b2b_ndone", nd, 2);
    if (nd >= 2) begin
      check_eq("b2b_k0", d_k[0], LAT);
      check_eq("b2b_k1", d_k[1], 2 * LAT + 1);
      check_eq("b2b_rx0", d_rx[0], 8'h3C);
      check_eq("b2b_rx1", d_rx[1], 8'hC3);
      check_eq("b2b_m0", d_m[0], 1);
      check_eq("b2b_m1", d_m[1], 1);
    end
    model_rx[0] = 8'hC3;
    model_m[0]  = 1'b1;

    xfer(0, 8'h77, 0, -1, 6);
    xfer(0, 8'h5A, 0, -1, -1);
    xfer(0, 8'hA5, 0, -1, -1);
    xfer(0, 8'h3E, 0, 4, -1);
    xfer(1, 8'h01, 0, -1, -1);

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) begin
        abort = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("gap_aborted", abt_m, 0);
        check_eq("gap_done", done_m, 0);
      end
      abort = 1'b0;
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W + D)) : -1;
      xfer(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 4) == 0), ak, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
